w5300_common_init_seq: RTL
==========================

W5300_COMMON_INIT_SEQ -- requirements
Module: w5300_common_init_seq

Interface
REQ-001 Parameter STARTUP_WAIT, default 16'd1000, idle cycles after start before the first bus access.
REQ-002 Parameter ACK_TIMEOUT, default 16'd255, maximum cycles a request may wait for bus_ack.
REQ-003 Parameter VERIFY, default 1'b1, enables read-back compare after each write.
REQ-004 clk  in  1  single clock; every flop is rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that starts the sequence.
REQ-007 lut_index  out  6  table index driven to the common-register config table.
REQ-008 lut_data  in  27  table entry: [26] op (1 = read, 0 = write), [25:16] register address, [15:0] write value.
REQ-009 bus_req  out  1  register-access request to the W5300 bus driver.
REQ-010 bus_wr  out  1  1 = write, 0 = read; valid while bus_req is high.
REQ-011 bus_addr  out  10  register address; valid while bus_req is high.
REQ-012 bus_wdata  out  16  write data; valid while bus_req is high.
REQ-013 bus_ack  in  1  one-cycle pulse marking completion of the current access.
REQ-014 bus_rdata  in  16  read data; valid in the bus_ack cycle.
REQ-015 busy, done, err  out  1 each  status flags.
REQ-016 err_index  out  6  table index at which the failure occurred.

Function
REQ-017 The block SHALL implement states IDLE, WAIT, FETCH, WR, RD, CHECK, DONE and ERROR.
REQ-018 IDLE/DONE/ERROR + start: clear done, err and the wait counter; set lut_index = 0 and busy = 1; go to WAIT.
REQ-019 A start pulse arriving while busy = 1 SHALL be ignored.
REQ-020 WAIT SHALL last exactly STARTUP_WAIT cycles and then go to FETCH; STARTUP_WAIT = 0 SHALL go to FETCH on the next cycle.
REQ-021 FETCH SHALL register lut_data in one cycle; lut_data is combinational from lut_index.
REQ-022 Terminator is op = 1 with address 10'h3ff; on a terminator FETCH SHALL go to DONE without issuing a bus access.
REQ-023 An op = 0 entry SHALL go to WR; an op = 1 entry that is not a terminator SHALL go to RD, and its read data is discarded.
REQ-024 Handshake: bus_req SHALL assert together with stable bus_wr, bus_addr and bus_wdata, and hold them until the cycle bus_ack is sampled high.
REQ-025 bus_req SHALL be low in the cycle after bus_ack and SHALL not reassert for at least one cycle.
REQ-026 bus_ack received while bus_req is low SHALL be ignored.
REQ-027 WR + bus_ack: if VERIFY = 1 and the address is not 10'h000, go to RD of the same address and then CHECK; otherwise advance.
REQ-028 CHECK SHALL compare the latched bus_rdata with the written value; on mismatch go to ERROR, otherwise advance.
REQ-029 Advance: if lut_index = 6'h3f, go to DONE with no wrap to 0; otherwise increment lut_index and go to FETCH.
REQ-030 An 8-bit-minimum timeout counter SHALL restart at each request rise; reaching ACK_TIMEOUT with no ack SHALL drop bus_req and go to ERROR.
REQ-031 DONE SHALL hold done = 1 and busy = 0 until the next start.
REQ-032 ERROR SHALL hold err = 1, busy = 0 and err_index = the failing index until the next start.
REQ-033 Entries SHALL be issued strictly in index order with one outstanding access at most.

Reset
REQ-034 While rst is high the block SHALL be in IDLE, with lut_index, bus_req, bus_wr, bus_addr, bus_wdata, busy, done, err, err_index and all counters at 0.
REQ-035 Reset asserted mid-access SHALL drop bus_req asynchronously, and no access SHALL resume after reset deasserts.

Structure
REQ-036 A shared package w5300_pkg SHALL hold: the entry field positions, ADDR_OP_RD/ADDR_OP_WR, the terminator address 10'h3ff, the MR address 10'h000, and the state encodings.
REQ-037 The block SHALL instantiate no sub-modules; the config table is instantiated beside it by the parent.
REQ-038 The timeout counter is natural as an in-file counter and SHALL not become a separate module.

Verification
REQ-039 Scenario: 15-entry table plus terminator, VERIFY = 0, 1-cycle ack -> 15 writes in order (first: addr 10'h000, data 16'hb910); done = 1; bus_req never asserted for 10'h3ff.
REQ-040 Scenario: VERIFY = 1, model echoes written data -> each write except addr 10'h000 is followed by a read of the same address; done = 1, err = 0.
REQ-041 Scenario: VERIFY = 1, model returns 16'h0000 for SIPR2 (index 10) -> err = 1, err_index = 6'd10; no access to index 11.
REQ-042 Scenario: ACK_TIMEOUT = 8, no ack at index 3 -> bus_req drops after 8 cycles; err = 1, err_index = 3.
REQ-043 Scenario: rst pulsed mid-write at index 5, then start -> outputs are 0 during reset; after start the sequence restarts at index 0 after STARTUP_WAIT cycles.
REQ-044 Scenario: start pulsed while busy, and ack held high for 3 cycles -> the extra start has no effect and each entry is issued exactly once.

Source files
------------

// File: rtl/w5300_pkg.sv
// W5300 common-register init sequencer: shared definitions.
//
// Holds the layout of a config-table entry, the op encodings, the special
// register addresses the sequencer cares about, and the sequencer state
// encoding.  Imported by w5300_common_init_seq and by anything that builds
// or inspects config-table entries.
//
// Entry layout (27 bits):
//   [26]    op     (ADDR_OP_RD = 1 read, ADDR_OP_WR = 0 write)
//   [25:16] register address
//   [15:0]  write value
package w5300_pkg;

    localparam int ENTRY_W  = 27;
    localparam int OP_BIT   = 26;
    localparam int ADDR_MSB = 25;
    localparam int ADDR_LSB = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;

    localparam logic ADDR_OP_RD = 1'b1;
    localparam logic ADDR_OP_WR = 1'b0;

    // A read of this address marks the end of the table.
    localparam logic [9:0] TERM_ADDR = 10'h3ff;

    // Mode register: writing it can soft-reset the chip, so it is never read back.
    localparam logic [9:0] MR_ADDR = 10'h000;

    localparam logic [5:0] LAST_INDEX = 6'h3f;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_WR    = 3'd3,
        ST_RD    = 3'd4,
        ST_CHECK = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERROR = 3'd7
    } state_t;

    // True when the entry is the end-of-table marker.
    function automatic logic is_terminator(input logic [ENTRY_W-1:0] entry);
        return (entry[OP_BIT] == ADDR_OP_RD) && (entry[ADDR_MSB:ADDR_LSB] == TERM_ADDR);
    endfunction

endpackage

// File: rtl/w5300_common_init_seq.sv
// W5300 common-register init sequencer.
//
// After a start pulse, waits STARTUP_WAIT cycles for the chip to come out
// of reset, then walks the external config table from index 0, issuing one
// register access per entry to the W5300 bus driver.  Writes may be read
// back and compared (VERIFY).  The walk stops at a terminator entry, after
// index 63, on a verify mismatch, or when an access is not acknowledged
// within ACK_TIMEOUT cycles.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle pulse, ignored while busy
//   lut_index/lut_data  table index out, combinational table entry in
//   bus_req/bus_wr/bus_addr/bus_wdata  access request, held until bus_ack
//   bus_ack/bus_rdata  completion pulse and read data from the bus driver
//   busy/done/err/err_index  status; err_index is the failing table index
module w5300_common_init_seq
    import w5300_pkg::*;
#(
    parameter logic [15:0] STARTUP_WAIT = 16'd1000,
    parameter logic [15:0] ACK_TIMEOUT  = 16'd255,
    parameter logic        VERIFY       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [5:0]  lut_index,
    input  logic [26:0] lut_data,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [9:0]  bus_addr,
    output logic [15:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [5:0]  err_index
);

    state_t      state, state_n;
    logic [5:0]  index_n;
    logic        req_n, wr_n;
    logic [9:0]  addr_n;
    logic [15:0] wdata_n;
    logic [15:0] wait_cnt, wait_cnt_n;
    logic [15:0] to_cnt, to_cnt_n;
    logic [15:0] rdata_q, rdata_n;
    logic        verify_rd, verify_rd_n;
    logic        busy_n, done_n, err_n;
    logic [5:0]  err_index_n;
    logic        advance;
    logic        ack_timeout;

    // The request is one cycle from timing out when the next count would
    // reach ACK_TIMEOUT; widened so ACK_TIMEOUT = 0 cannot wrap.
    assign ack_timeout = ({1'b0, to_cnt} + 17'd1) >= {1'b0, ACK_TIMEOUT};

    // Next-state and next-register logic.  Every register holds by default.
    // WR and RD raise bus_req in their first cycle (entered with bus_req low),
    // which guarantees at least one low cycle between back-to-back accesses.
    always_comb begin
        state_n     = state;
        index_n     = lut_index;
        req_n       = bus_req;
        wr_n        = bus_wr;
        addr_n      = bus_addr;
        wdata_n     = bus_wdata;
        wait_cnt_n  = wait_cnt;
        to_cnt_n    = to_cnt;
        rdata_n     = rdata_q;
        verify_rd_n = verify_rd;
        busy_n      = busy;
        done_n      = done;
        err_n       = err;
        err_index_n = err_index;
        advance     = 1'b0;

        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    done_n      = 1'b0;
                    err_n       = 1'b0;
                    err_index_n = 6'd0;
                    wait_cnt_n  = 16'd0;
                    index_n     = 6'd0;
                    busy_n      = 1'b1;
                    state_n     = (STARTUP_WAIT == 16'd0) ? ST_FETCH : ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (wait_cnt == STARTUP_WAIT - 16'd1) begin
                    state_n = ST_FETCH;
                end else begin
                    wait_cnt_n = wait_cnt + 16'd1;
                end
            end

            ST_FETCH: begin
                verify_rd_n = 1'b0;
                if (is_terminator(lut_data)) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    addr_n  = lut_data[ADDR_MSB:ADDR_LSB];
                    wdata_n = lut_data[DATA_MSB:DATA_LSB];
                    state_n = (lut_data[OP_BIT] == ADDR_OP_WR) ? ST_WR : ST_RD;
                end
            end

            ST_WR, ST_RD: begin
                if (!bus_req) begin
                    req_n    = 1'b1;
                    wr_n     = (state == ST_WR);
                    to_cnt_n = 16'd0;
                end else if (bus_ack) begin
                    req_n = 1'b0;
                    wr_n  = 1'b0;
                    if (state == ST_WR) begin
                        if (VERIFY && (bus_addr != MR_ADDR)) begin
                            state_n     = ST_RD;
                            verify_rd_n = 1'b1;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        rdata_n = bus_rdata;
                        if (verify_rd) begin
                            state_n = ST_CHECK;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end else if (ack_timeout) begin
                    req_n       = 1'b0;
                    wr_n        = 1'b0;
                    state_n     = ST_ERROR;
                    err_n       = 1'b1;
                    busy_n      = 1'b0;
                    err_index_n = lut_index;
                end else begin
                    to_cnt_n = to_cnt + 16'd1;
                end
            end

            ST_CHECK: begin
                if (rdata_q != bus_wdata) begin
                    state_n     = ST_ERROR;
                    err_n       = 1'b1;
                    busy_n      = 1'b0;
                    err_index_n = lut_index;
                end else begin
                    advance = 1'b1;
                end
            end

            default: state_n = ST_IDLE;
        endcase

        // Move to the next entry; index 63 is the last one, with no wrap.
        if (advance) begin
            if (lut_index == LAST_INDEX) begin
                state_n = ST_DONE;
                done_n  = 1'b1;
                busy_n  = 1'b0;
            end else begin
                index_n = lut_index + 6'd1;
                state_n = ST_FETCH;
            end
        end
    end

    // State and datapath registers.  Reset clears everything, so an access
    // in flight is dropped immediately and nothing resumes until a new start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lut_index <= 6'd0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= 10'd0;
            bus_wdata <= 16'd0;
            wait_cnt  <= 16'd0;
            to_cnt    <= 16'd0;
            rdata_q   <= 16'd0;
            verify_rd <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_index <= 6'd0;
        end else begin
            state     <= state_n;
            lut_index <= index_n;
            bus_req   <= req_n;
            bus_wr    <= wr_n;
            bus_addr  <= addr_n;
            bus_wdata <= wdata_n;
            wait_cnt  <= wait_cnt_n;
            to_cnt    <= to_cnt_n;
            rdata_q   <= rdata_n;
            verify_rd <= verify_rd_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            err_index <= err_index_n;
        end
    end

endmodule
